// File: rtl/sram_access_sequencer.sv
// Clocked valid/ready front end for an asynchronous SRAM.
// Registered ce_n/oe_n/we_n strobes with setup, pulse and hold phases.
module sram_access_sequencer #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int RD_WAIT    = 2,
    parameter int WR_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] RD_INIT = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_INIT = CW'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] wdata;
    logic drive;
    logic accept;
    logic sample;
    logic ce_nx, oe_nx, we_nx, drive_nx;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign sample    = (state == RD) && (cnt == '0);
    assign sram_data = drive ? wdata : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        state_nx = WR_SETUP;
                    end else begin
                        state_nx = RD;
                        cnt_nx   = RD_INIT;
                    end
                end
            end
            RD: begin
                if (cnt == '0) state_nx = IDLE;
                else           cnt_nx   = cnt - 1'b1;
            end
            WR_SETUP: begin
                state_nx = WR_PULSE;
                cnt_nx   = WR_INIT;
            end
            WR_PULSE: begin
                if (cnt == '0) state_nx = WR_HOLD;
                else           cnt_nx   = cnt - 1'b1;
            end
            WR_HOLD: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they change only on clock edges.
    always_comb begin
        ce_nx    = (state_nx == IDLE);
        oe_nx    = (state_nx != RD);
        we_nx    = (state_nx != WR_PULSE);
        drive_nx = (state_nx == WR_SETUP) || (state_nx == WR_PULSE) ||
                   (state_nx == WR_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            drive     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            sram_addr <= '0;
            wdata     <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sram_ce_n <= ce_nx;
            sram_oe_n <= oe_nx;
            sram_we_n <= we_nx;
            drive     <= drive_nx;
            rsp_valid <= sample;
            if (sample) rsp_rdata <= sram_data;
            if (accept) begin
                sram_addr <= req_addr;
                wdata     <= req_wdata;
            end
        end
    end

endmodule
